// File: rtl/ama_riscv_id_ex_stage_pkg.sv
// Shared constants, FSM encoding and index helpers for the ID/EX pipeline stage.
// Imported by the stage top and by the load-use detector.
package ama_riscv_id_ex_stage_pkg;

  localparam int XLEN_DEF     = 32;
  localparam int ALU_OP_W_DEF = 4;
  localparam int REG_IDX_W    = 6;

  localparam logic [REG_IDX_W-1:0] RF_X0_ZERO = 6'd0;

  localparam logic [1:0] ALU_A_SEL_FWD_NONE = 2'd0;
  localparam logic [1:0] ALU_B_SEL_FWD_NONE = 2'd0;

  typedef enum logic {
    ID_EX_FSM_RUN = 1'b0,
    ID_EX_FSM_LU  = 1'b1
  } id_ex_fsm_e;

  // True when a source index names the same, non-x0, register as a destination
  function automatic logic idx_match(input logic [REG_IDX_W-1:0] src,
                                     input logic [REG_IDX_W-1:0] dst);
    return (src == dst) && (dst != RF_X0_ZERO);
  endfunction

endpackage

// File: rtl/ama_riscv_load_use_detect.sv
// Combinational load-use hazard compare between the load in EX and the ID sources.
// Kept separate so the WB-forwarding path can reuse the same compare.
module ama_riscv_load_use_detect
  import ama_riscv_id_ex_stage_pkg::*;
(
  input  logic                 valid_ex,
  input  logic                 load_inst_ex,
  input  logic                 reg_we_ex,
  input  logic [REG_IDX_W-1:0] rd_ex,
  input  logic [REG_IDX_W-1:0] rs1_id,
  input  logic [REG_IDX_W-1:0] rs2_id,
  output logic                 lu_hzd
);

  logic ex_is_load_wr_s;

  assign ex_is_load_wr_s = valid_ex & load_inst_ex & reg_we_ex;
  // x0 loads never stall since idx_match excludes rd == x0
  assign lu_hzd = ex_is_load_wr_s &
                  (idx_match(rs1_id, rd_ex) | idx_match(rs2_id, rd_ex));

endmodule

// File: rtl/ama_riscv_id_ex_stage.sv
// ID/EX pipeline register with load-use stall/bubble control and branch/jump flush.
// stall_if_id is combinational from the FSM state and the hazard compare.
module ama_riscv_id_ex_stage
  import ama_riscv_id_ex_stage_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int ALU_OP_W = ALU_OP_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic [XLEN-1:0]      pc_id,
  input  logic [XLEN-1:0]      rs1_data_id,
  input  logic [XLEN-1:0]      rs2_data_id,
  input  logic [XLEN-1:0]      imm_id,
  input  logic [REG_IDX_W-1:0] rs1_id,
  input  logic [REG_IDX_W-1:0] rs2_id,
  input  logic [REG_IDX_W-1:0] rd_id,
  input  logic                 reg_we_id,
  input  logic                 load_inst_id,
  input  logic                 store_inst_id,
  input  logic                 branch_inst_id,
  input  logic [ALU_OP_W-1:0]  alu_op_id,
  input  logic [1:0]           alu_a_sel_fwd,
  input  logic [1:0]           alu_b_sel_fwd,
  input  logic                 bc_a_sel_fwd,
  input  logic                 bcs_b_sel_fwd,
  output logic [XLEN-1:0]      pc_ex,
  output logic [XLEN-1:0]      rs1_data_ex,
  output logic [XLEN-1:0]      rs2_data_ex,
  output logic [XLEN-1:0]      imm_ex,
  output logic [REG_IDX_W-1:0] rd_ex,
  output logic                 reg_we_ex,
  output logic                 load_inst_ex,
  output logic                 store_inst_ex,
  output logic                 branch_inst_ex,
  output logic [ALU_OP_W-1:0]  alu_op_ex,
  output logic [1:0]           alu_a_sel_fwd_ex,
  output logic [1:0]           alu_b_sel_fwd_ex,
  output logic                 bc_a_sel_fwd_ex,
  output logic                 bcs_b_sel_fwd_ex,
  output logic                 valid_ex,
  output logic                 stall_if_id
);

  id_ex_fsm_e state_r;
  id_ex_fsm_e state_nxt_s;
  logic       lu_hzd_s;
  logic       bubble_s;

  ama_riscv_load_use_detect u_load_use_detect (
    .valid_ex     (valid_ex),
    .load_inst_ex (load_inst_ex),
    .reg_we_ex    (reg_we_ex),
    .rd_ex        (rd_ex),
    .rs1_id       (rs1_id),
    .rs2_id       (rs2_id),
    .lu_hzd       (lu_hzd_s)
  );

  // Next-state, stall and bubble decision; flush outranks the load-use stall
  always_comb begin
    state_nxt_s = state_r;
    stall_if_id = 1'b0;
    bubble_s    = 1'b0;
    case (state_r)
      ID_EX_FSM_RUN: begin
        if (flush) begin
          bubble_s    = 1'b1;
          state_nxt_s = ID_EX_FSM_RUN;
        end else if (lu_hzd_s) begin
          bubble_s    = 1'b1;
          stall_if_id = 1'b1;
          state_nxt_s = ID_EX_FSM_LU;
        end else begin
          bubble_s    = 1'b0;
          state_nxt_s = ID_EX_FSM_RUN;
        end
      end
      ID_EX_FSM_LU: begin
        state_nxt_s = ID_EX_FSM_RUN;
        if (flush) begin
          bubble_s = 1'b1;
        end else begin
          bubble_s = 1'b0;
        end
      end
      default: begin
        state_nxt_s = ID_EX_FSM_RUN;
        bubble_s    = 1'b1;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ID_EX_FSM_RUN;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Control group: cleared on a bubble so nothing downstream acts on it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ex          <= RF_X0_ZERO;
      reg_we_ex      <= 1'b0;
      load_inst_ex   <= 1'b0;
      store_inst_ex  <= 1'b0;
      branch_inst_ex <= 1'b0;
      valid_ex       <= 1'b0;
    end else if (bubble_s) begin
      rd_ex          <= RF_X0_ZERO;
      reg_we_ex      <= 1'b0;
      load_inst_ex   <= 1'b0;
      store_inst_ex  <= 1'b0;
      branch_inst_ex <= 1'b0;
      valid_ex       <= 1'b0;
    end else begin
      rd_ex          <= rd_id;
      reg_we_ex      <= reg_we_id;
      load_inst_ex   <= load_inst_id;
      store_inst_ex  <= store_inst_id;
      branch_inst_ex <= branch_inst_id;
      valid_ex       <= 1'b1;
    end
  end

  // Forwarding-select group: a bubble selects the plain register-file path
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a_sel_fwd_ex <= ALU_A_SEL_FWD_NONE;
      alu_b_sel_fwd_ex <= ALU_B_SEL_FWD_NONE;
      bc_a_sel_fwd_ex  <= 1'b0;
      bcs_b_sel_fwd_ex <= 1'b0;
    end else if (bubble_s) begin
      alu_a_sel_fwd_ex <= ALU_A_SEL_FWD_NONE;
      alu_b_sel_fwd_ex <= ALU_B_SEL_FWD_NONE;
      bc_a_sel_fwd_ex  <= 1'b0;
      bcs_b_sel_fwd_ex <= 1'b0;
    end else begin
      alu_a_sel_fwd_ex <= alu_a_sel_fwd;
      alu_b_sel_fwd_ex <= alu_b_sel_fwd;
      bc_a_sel_fwd_ex  <= bc_a_sel_fwd;
      bcs_b_sel_fwd_ex <= bcs_b_sel_fwd;
    end
  end

  // Data group: meaningless in a bubble, so it simply holds to save toggling
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_ex       <= {XLEN{1'b0}};
      rs1_data_ex <= {XLEN{1'b0}};
      rs2_data_ex <= {XLEN{1'b0}};
      imm_ex      <= {XLEN{1'b0}};
      alu_op_ex   <= {ALU_OP_W{1'b0}};
    end else if (!bubble_s) begin
      pc_ex       <= pc_id;
      rs1_data_ex <= rs1_data_id;
      rs2_data_ex <= rs2_data_id;
      imm_ex      <= imm_id;
      alu_op_ex   <= alu_op_id;
    end
  end

endmodule

// File: tb/tb_ama_riscv_id_ex_stage.sv
// Self-checking bench for the ID/EX stage: directed vector table, reset and
// corner sequences, then random traffic against a behavioural pipeline model.
module tb_ama_riscv_id_ex_stage;
  import ama_riscv_id_ex_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush;
  logic [31:0] pc_id, rs1_data_id, rs2_data_id, imm_id;
  logic [5:0]  rs1_id, rs2_id, rd_id;
  logic        reg_we_id, load_inst_id, store_inst_id, branch_inst_id;
  logic [3:0]  alu_op_id;
  logic [1:0]  alu_a_sel_fwd, alu_b_sel_fwd;
  logic        bc_a_sel_fwd, bcs_b_sel_fwd;
  logic [31:0] pc_ex, rs1_data_ex, rs2_data_ex, imm_ex;
  logic [5:0]  rd_ex;
  logic        reg_we_ex, load_inst_ex, store_inst_ex, branch_inst_ex;
  logic [3:0]  alu_op_ex;
  logic [1:0]  alu_a_sel_fwd_ex, alu_b_sel_fwd_ex;
  logic        bc_a_sel_fwd_ex, bcs_b_sel_fwd_ex, valid_ex, stall_if_id;

  always #5 clk = ~clk;

  ama_riscv_id_ex_stage #(.XLEN(32), .ALU_OP_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .pc_id(pc_id), .rs1_data_id(rs1_data_id), .rs2_data_id(rs2_data_id), .imm_id(imm_id),
    .rs1_id(rs1_id), .rs2_id(rs2_id), .rd_id(rd_id),
    .reg_we_id(reg_we_id), .load_inst_id(load_inst_id), .store_inst_id(store_inst_id),
    .branch_inst_id(branch_inst_id), .alu_op_id(alu_op_id),
    .alu_a_sel_fwd(alu_a_sel_fwd), .alu_b_sel_fwd(alu_b_sel_fwd),
    .bc_a_sel_fwd(bc_a_sel_fwd), .bcs_b_sel_fwd(bcs_b_sel_fwd),
    .pc_ex(pc_ex), .rs1_data_ex(rs1_data_ex), .rs2_data_ex(rs2_data_ex), .imm_ex(imm_ex),
    .rd_ex(rd_ex), .reg_we_ex(reg_we_ex), .load_inst_ex(load_inst_ex),
    .store_inst_ex(store_inst_ex), .branch_inst_ex(branch_inst_ex), .alu_op_ex(alu_op_ex),
    .alu_a_sel_fwd_ex(alu_a_sel_fwd_ex), .alu_b_sel_fwd_ex(alu_b_sel_fwd_ex),
    .bc_a_sel_fwd_ex(bc_a_sel_fwd_ex), .bcs_b_sel_fwd_ex(bcs_b_sel_fwd_ex),
    .valid_ex(valid_ex), .stall_if_id(stall_if_id)
  );

  typedef struct packed {
    logic [31:0] pc, rs1d, rs2d, imm;
    logic [5:0]  rs1, rs2, rd;
    logic        we, ld, st, br;
    logic [3:0]  op;
    logic [1:0]  as, bs;
    logic        bca, bcsb;
  } id_t;

  typedef struct packed {
    logic [31:0] pc, rs1d, rs2d, imm;
    logic [5:0]  rd;
    logic        we, ld, st, br;
    logic [3:0]  op;
    logic [1:0]  as, bs;
    logic        bca, bcsb, valid;
  } ex_t;

  typedef struct {
    logic       flush;
    id_t        id;
    logic       exp_stall;
    logic       exp_valid;
    logic [5:0] exp_rd;
    logic       exp_we;
  } vec_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  ex_t  m_ex;
  logic m_stalled_last;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic id_t mk(input logic [31:0] pc, input logic [5:0] rs1, input logic [5:0] rs2,
                             input logic [5:0] rd, input logic we, input logic ld,
                             input logic [1:0] as, input logic [1:0] bs);
    id_t d;
    d = '0;
    d.pc = pc; d.rs1d = pc ^ 32'hA5A5_0001; d.rs2d = pc ^ 32'h5A5A_0002; d.imm = pc + 32'd4;
    d.rs1 = rs1; d.rs2 = rs2; d.rd = rd; d.we = we; d.ld = ld;
    d.op = pc[3:0]; d.as = as; d.bs = bs; d.bca = as[0]; d.bcsb = bs[1];
    return d;
  endfunction

  function automatic id_t rnd_id();
    id_t d;
    d.pc = $urandom; d.rs1d = $urandom; d.rs2d = $urandom; d.imm = $urandom;
    d.rs1 = 6'($urandom_range(0, 7)); d.rs2 = 6'($urandom_range(0, 7));
    d.rd = 6'($urandom_range(0, 7));
    d.we = ($urandom_range(0, 3) != 0); d.ld = ($urandom_range(0, 2) == 0);
    d.st = ($urandom_range(0, 4) == 0); d.br = ($urandom_range(0, 4) == 0);
    d.op = 4'($urandom); d.as = 2'($urandom); d.bs = 2'($urandom);
    d.bca = 1'($urandom); d.bcsb = 1'($urandom);
    return d;
  endfunction

  function automatic ex_t dut_ex();
    return '{pc_ex, rs1_data_ex, rs2_data_ex, imm_ex, rd_ex, reg_we_ex, load_inst_ex,
             store_inst_ex, branch_inst_ex, alu_op_ex, alu_a_sel_fwd_ex, alu_b_sel_fwd_ex,
             bc_a_sel_fwd_ex, bcs_b_sel_fwd_ex, valid_ex};
  endfunction

  // A real load writing a non-zero register that the ID instruction reads
  function automatic logic model_uses_load(input ex_t e, input id_t d);
    return e.valid && e.ld && e.we && (e.rd != 6'd0) && (d.rs1 == e.rd || d.rs2 == e.rd);
  endfunction

  task automatic drive(input logic fl, input id_t d);
    flush = fl;
    pc_id = d.pc; rs1_data_id = d.rs1d; rs2_data_id = d.rs2d; imm_id = d.imm;
    rs1_id = d.rs1; rs2_id = d.rs2; rd_id = d.rd;
    reg_we_id = d.we; load_inst_id = d.ld; store_inst_id = d.st; branch_inst_id = d.br;
    alu_op_id = d.op; alu_a_sel_fwd = d.as; alu_b_sel_fwd = d.bs;
    bc_a_sel_fwd = d.bca; bcs_b_sel_fwd = d.bcsb;
  endtask

  // One pipeline cycle: check the stall before the edge, the EX contents after it
  task automatic step(input logic fl, input id_t d, output logic st_seen);
    logic exp_st;
    drive(fl, d);
    #1;
    exp_st = !m_stalled_last && !fl && model_uses_load(m_ex, d);
    chk("stall", 160'(stall_if_id), 160'(exp_st));
    st_seen = stall_if_id;
    @(posedge clk);
    if (fl || exp_st) begin
      m_ex.rd = 6'd0; m_ex.we = 1'b0; m_ex.ld = 1'b0; m_ex.st = 1'b0; m_ex.br = 1'b0;
      m_ex.as = 2'd0; m_ex.bs = 2'd0; m_ex.bca = 1'b0; m_ex.bcsb = 1'b0; m_ex.valid = 1'b0;
    end else begin
      m_ex = '{d.pc, d.rs1d, d.rs2d, d.imm, d.rd, d.we, d.ld, d.st, d.br, d.op,
               d.as, d.bs, d.bca, d.bcsb, 1'b1};
    end
    m_stalled_last = exp_st;
    #1;
    chk("ex_regs", 160'(dut_ex()), 160'(m_ex));
  endtask

  vec_t vecs[$];
  logic st;
  int   stall_cnt;

  initial begin
    drive(1'b0, '0);
    m_ex = '0;
    m_stalled_last = 1'b0;
    #12;
    chk("reset_outputs", 160'(dut_ex()), 160'd0);
    chk("reset_stall", 160'(stall_if_id), 160'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // flush, id, exp_stall, exp_valid, exp_rd, exp_we
    vecs.push_back('{1'b0, mk(32'h100, 6'd1, 6'd2, 6'd3, 1'b1, 1'b0, 2'd0, 2'd0), 1'b0, 1'b1, 6'd3, 1'b1}); // add x3
    vecs.push_back('{1'b0, mk(32'h104, 6'd3, 6'd0, 6'd5, 1'b1, 1'b1, 2'd1, 2'd0), 1'b0, 1'b1, 6'd5, 1'b1}); // lw x5
    vecs.push_back('{1'b0, mk(32'h108, 6'd5, 6'd1, 6'd6, 1'b1, 1'b0, 2'd0, 2'd0), 1'b1, 1'b0, 6'd0, 1'b0}); // add x6,x5 stall
    vecs.push_back('{1'b0, mk(32'h108, 6'd5, 6'd1, 6'd6, 1'b1, 1'b0, 2'd2, 2'd0), 1'b0, 1'b1, 6'd6, 1'b1}); // re-presented
    vecs.push_back('{1'b0, mk(32'h10C, 6'd1, 6'd0, 6'd0, 1'b1, 1'b1, 2'd0, 2'd0), 1'b0, 1'b1, 6'd0, 1'b1}); // lw x0
    vecs.push_back('{1'b0, mk(32'h110, 6'd0, 6'd0, 6'd7, 1'b1, 1'b0, 2'd0, 2'd0), 1'b0, 1'b1, 6'd7, 1'b1}); // uses x0
    vecs.push_back('{1'b0, mk(32'h114, 6'd1, 6'd2, 6'd8, 1'b1, 1'b1, 2'd0, 2'd0), 1'b0, 1'b1, 6'd8, 1'b1}); // lw x8
    vecs.push_back('{1'b1, mk(32'h118, 6'd1, 6'd8, 6'd9, 1'b1, 1'b0, 2'd3, 2'd3), 1'b0, 1'b0, 6'd0, 1'b0}); // flush+hazard
    vecs.push_back('{1'b0, mk(32'h200, 6'd8, 6'd0, 6'd9, 1'b1, 1'b0, 2'd0, 2'd1), 1'b0, 1'b1, 6'd9, 1'b1}); // RUN kept
    vecs.push_back('{1'b0, mk(32'h204, 6'd1, 6'd0, 6'd5, 1'b1, 1'b1, 2'd0, 2'd0), 1'b0, 1'b1, 6'd5, 1'b1}); // lw x5
    vecs.push_back('{1'b0, mk(32'h208, 6'd5, 6'd0, 6'd6, 1'b1, 1'b1, 2'd0, 2'd0), 1'b1, 1'b0, 6'd0, 1'b0}); // lw x6,0(x5)
    vecs.push_back('{1'b0, mk(32'h208, 6'd5, 6'd0, 6'd6, 1'b1, 1'b1, 2'd2, 2'd0), 1'b0, 1'b1, 6'd6, 1'b1});
    vecs.push_back('{1'b0, mk(32'h20C, 6'd6, 6'd1, 6'd7, 1'b1, 1'b0, 2'd0, 2'd0), 1'b1, 1'b0, 6'd0, 1'b0}); // add x7,x6
    vecs.push_back('{1'b0, mk(32'h20C, 6'd6, 6'd1, 6'd7, 1'b1, 1'b0, 2'd2, 2'd1), 1'b0, 1'b1, 6'd7, 1'b1});
    vecs.push_back('{1'b0, mk(32'h300, 6'd1, 6'd0, 6'd10, 1'b1, 1'b1, 2'd0, 2'd0), 1'b0, 1'b1, 6'd10, 1'b1}); // lw x10
    vecs.push_back('{1'b0, mk(32'h304, 6'd10, 6'd0, 6'd11, 1'b1, 1'b0, 2'd0, 2'd0), 1'b1, 1'b0, 6'd0, 1'b0});
    vecs.push_back('{1'b1, mk(32'h304, 6'd10, 6'd0, 6'd11, 1'b1, 1'b0, 2'd2, 2'd0), 1'b0, 1'b0, 6'd0, 1'b0}); // flush in LU
    vecs.push_back('{1'b0, mk(32'h400, 6'd10, 6'd0, 6'd11, 1'b1, 1'b0, 2'd1, 2'd2), 1'b0, 1'b1, 6'd11, 1'b1});

    stall_cnt = 0;
    foreach (vecs[i]) begin
      step(vecs[i].flush, vecs[i].id, st);
      chk($sformatf("tbl%0d_stall", i), 160'(st), 160'(vecs[i].exp_stall));
      chk($sformatf("tbl%0d_valid", i), 160'(valid_ex), 160'(vecs[i].exp_valid));
      chk($sformatf("tbl%0d_rd", i), 160'(rd_ex), 160'(vecs[i].exp_rd));
      chk($sformatf("tbl%0d_we", i), 160'(reg_we_ex), 160'(vecs[i].exp_we));
      if (i >= 9 && i <= 13) stall_cnt += int'(st);
    end
    chk("b2b_stall_count", 160'(stall_cnt), 160'd2);

    // Reset mid-run while EX holds lw x5 and ID depends on it
    step(1'b0, mk(32'h500, 6'd1, 6'd0, 6'd5, 1'b1, 1'b1, 2'd0, 2'd0), st);
    chk("pre_reset_rd", 160'(rd_ex), 160'd5);
    drive(1'b0, mk(32'h504, 6'd5, 6'd0, 6'd6, 1'b1, 1'b0, 2'd0, 2'd0));
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrun_reset_outputs", 160'(dut_ex()), 160'd0);
    chk("midrun_reset_stall", 160'(stall_if_id), 160'd0);
    m_ex = '0;
    m_stalled_last = 1'b0;
    #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    step(1'b0, mk(32'h504, 6'd5, 6'd0, 6'd6, 1'b1, 1'b0, 2'd0, 2'd0), st);
    step(1'b0, mk(32'h508, 6'd1, 6'd0, 6'd5, 1'b1, 1'b1, 2'd0, 2'd0), st);
    step(1'b0, mk(32'h50C, 6'd0, 6'd5, 6'd6, 1'b1, 1'b0, 2'd0, 2'd0), st);
    chk("post_reset_stall", 160'(st), 160'd1);

    for (int k = 0; k < 400; k++) begin
      step(($urandom_range(0, 7) == 0), rnd_id(), st);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
